instr_fetch_decode: RTL
=======================

Name: instr_fetch_decode

Overview:
- Instruction register, opcode decoder and run/step gate. Sits directly upstream of the multicycle control FSM.
- Captures the 16-bit word from code memory and decodes it into the 27-bit opcode bus the FSM consumes: 23-bit one-hot, RX, RY.
- Produces the FSM's run input, supporting continuous or single-step execution.
- Keeps a retired-instruction counter.

Parameters:
- COUNT_W, 16, width of retired-instruction counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- run_mode  input  1  1 = continuous, 0 = single-step.
- step  input  1  step button, already synchronised, level.
- instr_in  input  16  word from code memory.
- ir_load  input  1  from FSM fetch state: capture instr_in.
- instr_done  input  1  from FSM: last cycle of current instruction.
- opcode_out  output  27  [22:0] one-hot op, [24:23] RY, [26:25] RX.
- imm_out  output  8  immediate field.
- decode_valid  output  1  opcode_out reflects current IR.
- run  output  1  run enable to FSM.
- instr_count  output  COUNT_W  retired instructions.
- illegal  output  1  current IR holds an undefined encoding.

Behaviour:
- Reset is asynchronous. Reset values:
  - ir = 0, opcode_out = 27'h1 (NOOP, RX = RY = 0), imm_out = 0
  - decode_valid = 0, run = 0, instr_count = 0, illegal = 0
  - gate FSM = IDLE, step_q = 0
- Reset mid-instruction aborts everything immediately.
- Pipeline, two stages:
  - Edge N with ir_load = 1: ir <= instr_in and decode_valid <= 0.
  - Edge N+1: opcode_out, imm_out and illegal are registered from ir, and decode_valid <= 1.
  - decode_valid stays 1 until the next ir_load edge.
  - Back-to-back ir_load: each new word overrides the previous one; outputs always follow the latest IR, with latency 1 edge after capture.
- Field mapping:
  - op = ir[15:12], RX = ir[11:10], RY = ir[9:8], imm = ir[7:0].
  - opcode_out[26:25] = RX, opcode_out[24:23] = RY, imm_out = imm.
- One-hot index by opcode:
  - 0 NOOP
  - 1: indices 1-4 INPUTC/INPUTCF/INPUTD/INPUTDF, selected by ir[9:8] = 00/01/10/11
  - 2 -> 5 MOVE, 3 -> 6 LOADI/LOADP
  - 4 -> 7 ADD, 5 -> 8 ADDI, 6 -> 9 SUB, 7 -> 10 SUBI
  - 8 -> 11 LOAD, 9 -> 12 LOADF, A -> 13 STORE, B -> 14 STOREF
  - C: 15 SHIFTL (ir[9:8] = 00), 16 SHIFTR (ir[9:8] = 01)
  - D -> 17 CMP, E -> 18 JUMP
  - F: indices 19-22 BRE/BRNE/BRG/BRGE, selected by ir[9:8] = 00/01/10/11
- Illegal encoding: op = C with ir[9] = 1.
  - opcode_out[22:0] = NOOP (bit 0).
  - RX/RY still passed through.
  - illegal = 1 for as long as that word is decoded.
- Gate FSM: states IDLE, RUNNING, STEP_EXEC, STEP_HOLD. run = 1 in RUNNING and STEP_EXEC only. Transitions:
  - IDLE: run_mode = 1 -> RUNNING; step rising edge (step & ~step_q) -> STEP_EXEC.
  - RUNNING: run_mode = 0 -> stays RUNNING until instr_done, then IDLE. An instruction is never cut.
  - STEP_EXEC: instr_done -> STEP_HOLD.
  - STEP_HOLD: step = 0 -> IDLE. Holding the button never produces a second step.
  - A step edge while RUNNING is ignored.
- instr_count:
  - Increments on every edge where instr_done & run.
  - Wraps from all-ones to 0.
  - If instr_done and ir_load occur in the same cycle, both take effect.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - Adds state TRAPPED, entered from any state on the edge where decode_valid = 1 and illegal = 1.
  - In TRAPPED, run = 0 and run_mode and step are ignored.
  - Only reset exits TRAPPED.
- Undefined: no TRAPPED state; the illegal word executes as NOOP and illegal is indicator-only.

Test Plan:
- Reset, then ir_load with instr_in = 16'h5A07 (ADDI RX = 2, RY = 2, imm = 7) -> one edge later opcode_out = {2'b10, 2'b10, bit 8 set} = 27'h5000100, imm_out = 8'h07, decode_valid = 1.
- Sweep all 16 opcodes × ir[9:8] -> exactly one bit of [22:0] set, matching the index table. 16'hC200 and 16'hC300 -> bit 0 set, illegal = 1.
- run_mode = 0, hold step high 20 cycles, instr_done pulsed at cycle 5 -> run high only from step edge until instr_done; exactly one count; no second step until step released and pressed again.
- run_mode = 1, 10 instr_done pulses, drop run_mode mid-instruction -> run stays 1 until next instr_done, then 0; instr_count = 11.
- Preload count to all-ones via 2^COUNT_W − 1 pulses (COUNT_W = 4 build), one more pulse -> 0. Assert reset mid-STEP_EXEC -> all outputs at reset values immediately.
- ILLEGAL_TRAP_EN build, run_mode = 1, load 16'hC200 -> run = 0 one edge after decode_valid, stays 0 despite step/run_mode until reset. Non-macro build -> run stays 1.

Source files
------------

// File: rtl/instr_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_decode
// Description : Instruction register, opcode decoder and run/step gate that
//               sit directly upstream of the multicycle control FSM. Keeps a
//               retired-instruction counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   COUNT_W       width of the retired-instruction counter (default 16)
// Ports
//   clock         system clock, rising edge
//   reset         asynchronous, active-high
//   run_mode      1 = continuous execution, 0 = single-step
//   step          step button (already synchronised), level
//   instr_in      16-bit word from code memory
//   ir_load       FSM fetch state: capture instr_in into the IR
//   instr_done    FSM: last cycle of the current instruction
//   opcode_out    [22:0] one-hot op, [24:23] RY, [26:25] RX
//   imm_out       8-bit immediate field
//   decode_valid  opcode_out/imm_out/illegal reflect the current IR
//   run           run enable to the FSM
//   instr_count   retired instructions (wraps)
//   illegal       decoded IR holds an undefined encoding
// Build option
//   ILLEGAL_TRAP_EN  when defined, a decoded illegal word parks the gate in a
//                    TRAPPED state (run = 0) that only reset leaves.
// ============================================================================
module instr_fetch_decode #(
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run_mode,
  input  logic               step,
  input  logic [15:0]        instr_in,
  input  logic               ir_load,
  input  logic               instr_done,
  output logic [26:0]        opcode_out,
  output logic [7:0]         imm_out,
  output logic               decode_valid,
  output logic               run,
  output logic [COUNT_W-1:0] instr_count,
  output logic               illegal
);

  localparam logic [26:0] C_OPCODE_RESET = 27'h0000001;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUNNING   = 3'd1,
    S_STEP_EXEC = 3'd2,
    S_STEP_HOLD = 3'd3
`ifdef ILLEGAL_TRAP_EN
    , S_TRAPPED = 3'd4
`endif
  } gate_state_t;

  logic [15:0] r_ir;
  logic        r_ir_valid;   // at least one word captured since reset
  logic        r_step_q;
  gate_state_t r_state;
  gate_state_t w_state_next;

  logic [3:0]  w_op;
  logic [1:0]  w_sel;
  logic [22:0] w_onehot;
  logic        w_illegal;

  // --------------------------------------------------------------------------
  // Opcode decode (combinational from IR, registered into the outputs below)
  // --------------------------------------------------------------------------
  assign w_op  = r_ir[15:12];
  assign w_sel = r_ir[9:8];

  always_comb begin
    w_onehot  = '0;
    w_illegal = 1'b0;
    case (w_op)
      4'h0: w_onehot = 23'd1;
      4'h1: w_onehot = 23'd1 << (5'd1 + {3'b000, w_sel});
      4'h2: w_onehot = 23'd1 << 5;
      4'h3: w_onehot = 23'd1 << 6;
      4'h4: w_onehot = 23'd1 << 7;
      4'h5: w_onehot = 23'd1 << 8;
      4'h6: w_onehot = 23'd1 << 9;
      4'h7: w_onehot = 23'd1 << 10;
      4'h8: w_onehot = 23'd1 << 11;
      4'h9: w_onehot = 23'd1 << 12;
      4'hA: w_onehot = 23'd1 << 13;
      4'hB: w_onehot = 23'd1 << 14;
      4'hC: begin
        // Only SHIFTL/SHIFTR exist; the upper sub-codes fall back to NOOP.
        if (w_sel[1]) begin
          w_onehot  = 23'd1;
          w_illegal = 1'b1;
        end else if (w_sel[0]) begin
          w_onehot = 23'd1 << 16;
        end else begin
          w_onehot = 23'd1 << 15;
        end
      end
      4'hD: w_onehot = 23'd1 << 17;
      4'hE: w_onehot = 23'd1 << 18;
      4'hF: w_onehot = 23'd1 << (5'd19 + {3'b000, w_sel});
      default: w_onehot = 23'd1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Two-stage pipeline: IR capture, then registered decode one edge later.
  // Decode is re-registered every edge so the outputs always follow the
  // newest IR; decode_valid is held low on any capture edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ir         <= '0;
      r_ir_valid   <= 1'b0;
      opcode_out   <= C_OPCODE_RESET;
      imm_out      <= '0;
      illegal      <= 1'b0;
      decode_valid <= 1'b0;
    end else begin
      if (ir_load) begin
        r_ir       <= instr_in;
        r_ir_valid <= 1'b1;
      end
      opcode_out   <= {r_ir[11:10], r_ir[9:8], w_onehot};
      imm_out      <= r_ir[7:0];
      illegal      <= w_illegal;
      decode_valid <= r_ir_valid & ~ir_load;
    end
  end

  // --------------------------------------------------------------------------
  // Run/step gate
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_step_q <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_step_q <= step;
    end
  end

  always_comb begin
    w_state_next = r_state;
    run          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run_mode) begin
          w_state_next = S_RUNNING;
        end else if (step && !r_step_q) begin
          w_state_next = S_STEP_EXEC;
        end
      end
      S_RUNNING: begin
        run = 1'b1;
        // Dropping run_mode only takes effect at an instruction boundary.
        if (!run_mode && instr_done) begin
          w_state_next = S_IDLE;
        end
      end
      S_STEP_EXEC: begin
        run = 1'b1;
        if (instr_done) begin
          w_state_next = S_STEP_HOLD;
        end
      end
      S_STEP_HOLD: begin
        // Wait for release so a held button yields exactly one step.
        if (!step) begin
          w_state_next = S_IDLE;
        end
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAPPED: begin
        w_state_next = S_TRAPPED;
      end
`endif
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
`ifdef ILLEGAL_TRAP_EN
    if (decode_valid && illegal) begin
      w_state_next = S_TRAPPED;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // Retired-instruction counter (wraps naturally)
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_count <= '0;
    end else if (instr_done && run) begin
      instr_count <= instr_count + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
`default_nettype wire
